id_stage_pipe: RTL and testbench

Parametrised successor to the single-cycle decode stage. Holds the integer register file, immediate generator, main control and ALU decoder, and adds a registered ID/EX output with valid/ready handshake, flush, write-back bypass, operand refresh while stalled, illegal-instruction detection and an RV32E mode. Sits between the fetch stage and the execute stage of the pipelined core.

---
 rtl/id_pkg.sv | 57 +++++
 rtl/id_decode.sv | 123 ++++++++++++
 rtl/id_stage_pipe.sv | 166 ++++++++++++++++
 tb/tb_id_stage_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions: opcodes, ALU operation encodings and control-bit positions.
package id_pkg;

  localparam int unsigned CTRL_W        = 11;
  localparam int unsigned CTRL_REGWRITE = 10;
  localparam int unsigned CTRL_MEMREAD  = 9;
  localparam int unsigned CTRL_MEMWRITE = 8;
  localparam int unsigned CTRL_MEMTOREG = 7;
  localparam int unsigned CTRL_ALUSRC   = 6;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_JAL      = 4;
  localparam int unsigned CTRL_JALR     = 3;
  localparam int unsigned CTRL_LUI      = 2;
  localparam int unsigned CTRL_AUIPC    = 1;
  localparam int unsigned CTRL_PCTOALU  = 0;

  localparam int unsigned ALU_W = 4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  localparam logic [ALU_W-1:0] ALU_ADD    = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_SUB    = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_AND    = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_OR     = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_XOR    = 4'b0100;
  localparam logic [ALU_W-1:0] ALU_SLL    = 4'b0101;
  localparam logic [ALU_W-1:0] ALU_SRL    = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SRA    = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_SLT    = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SLTU   = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_PASS_B = 4'b1111;

  // Arithmetic op selected by funct3; alt picks SUB/SRA over ADD/SRL.
  function automatic logic [ALU_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational instruction decoder: immediate, control word, ALU op and illegal flag.
module id_decode
  import id_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic [31:0]       instr_i,
  output logic [XLEN-1:0]   imm_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ALU_W-1:0]  alu_ctrl_o,
  output logic              illegal_o
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd, rs1, rs2;
  logic [31:0]       imm32;
  logic [CTRL_W-1:0] ctrl_raw;
  logic              use_rs1, use_rs2, use_rd;
  logic              known, bad_enc, bad_reg;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];

  always_comb begin
    imm32      = '0;
    ctrl_raw   = '0;
    alu_ctrl_o = ALU_ADD;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    known      = 1'b1;
    bad_enc    = 1'b0;
    case (opcode)
      OPC_OP_IMM: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        ctrl_raw[CTRL_ALUSRC]   = 1'b1;
        {use_rs1, use_rd} = 2'b11;
        alu_ctrl_o = alu_from_f3(funct3, (funct3 == 3'b101) && instr_i[30]);
        if (funct3 == 3'b001 && funct7 != 7'b0000000) bad_enc = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000) bad_enc = 1'b1;
      end
      OPC_OP: begin
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        {use_rs1, use_rs2, use_rd} = 3'b111;
        alu_ctrl_o = alu_from_f3(funct3, instr_i[30]);
        bad_enc = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OPC_LOAD: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        ctrl_raw[CTRL_MEMREAD]  = 1'b1;
        ctrl_raw[CTRL_MEMTOREG] = 1'b1;
        ctrl_raw[CTRL_ALUSRC]   = 1'b1;
        {use_rs1, use_rd} = 2'b11;
      end
      OPC_STORE: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        ctrl_raw[CTRL_MEMWRITE] = 1'b1;
        ctrl_raw[CTRL_ALUSRC]   = 1'b1;
        {use_rs1, use_rs2} = 2'b11;
      end
      OPC_BRANCH: begin
        imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        ctrl_raw[CTRL_BRANCH] = 1'b1;
        {use_rs1, use_rs2} = 2'b11;
        case (funct3[2:1])
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_SUB;
        endcase
      end
      OPC_JAL: begin
        imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        ctrl_raw[CTRL_JAL]      = 1'b1;
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        ctrl_raw[CTRL_ALUSRC]   = 1'b1;
        ctrl_raw[CTRL_JALR]     = 1'b1;
        {use_rs1, use_rd} = 2'b11;
      end
      OPC_LUI: begin
        imm32 = {instr_i[31:12], 12'b0};
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        ctrl_raw[CTRL_ALUSRC]   = 1'b1;
        ctrl_raw[CTRL_LUI]      = 1'b1;
        use_rd = 1'b1;
        alu_ctrl_o = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        imm32 = {instr_i[31:12], 12'b0};
        ctrl_raw[CTRL_REGWRITE] = 1'b1;
        ctrl_raw[CTRL_ALUSRC]   = 1'b1;
        ctrl_raw[CTRL_AUIPC]    = 1'b1;
        ctrl_raw[CTRL_PCTOALU]  = 1'b1;
        use_rd = 1'b1;
      end
      OPC_SYSTEM, OPC_FENCE: ;
      default: known = 1'b0;
    endcase
  end

  // Register indices beyond the implemented file (RV32E) are illegal where actually used.
  assign bad_reg = (use_rs1 && 32'(rs1) >= NREGS) ||
                   (use_rs2 && 32'(rs2) >= NREGS) ||
                   (use_rd  && 32'(rd)  >= NREGS);

  assign illegal_o = !known || bad_enc || bad_reg;
  assign ctrl_o    = illegal_o ? '0 : ctrl_raw;
  assign imm_o     = XLEN'($signed(imm32));

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined decode stage: register file, decoder and a handshaked ID/EX register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_funct3,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ALU_W-1:0]  out_alu_ctrl,
  output logic              out_illegal
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]   rf_q [NREGS];
  logic [4:0]        rs_idx [2];
  logic [XLEN-1:0]   rs_val [2];
  logic              wb_we, accept;

  logic [XLEN-1:0]   dec_imm;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [ALU_W-1:0]  dec_alu;
  logic              dec_illegal;

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d, imm_q, imm_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [ALU_W-1:0]  alu_q, alu_d;
  logic              illegal_q, illegal_d;

  id_decode #(.XLEN(XLEN), .NREGS(NREGS)) u_decode (
    .instr_i    (in_instr),
    .imm_o      (dec_imm),
    .ctrl_o     (dec_ctrl),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );

  assign in_ready = !reset && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign wb_we    = wb_en && (wb_rd != 5'd0) && (32'(wb_rd) < NREGS);

  assign rs_idx[0] = in_instr[19:15];
  assign rs_idx[1] = in_instr[24:20];

  // Read ports: x0 is hardwired, optional same-cycle forwarding from write-back.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_val[p] = '0;
      if (rs_idx[p] != 5'd0) begin
        if (BYPASS != 0 && wb_en && wb_rd == rs_idx[p]) rs_val[p] = wb_data;
        else if (32'(rs_idx[p]) < NREGS) rs_val[p] = rf_q[AW'(rs_idx[p])];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_we) begin
      rf_q[AW'(wb_rd)] <= wb_data;
    end
  end

  // ID/EX next state: capture on accept, otherwise refresh stalled operands from write-back.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    funct3_d  = funct3_q;
    ctrl_d    = ctrl_q;
    alu_d     = alu_q;
    illegal_d = illegal_q;
    if (accept) begin
      pc_d      = in_pc;
      rs1_val_d = rs_val[0];
      rs2_val_d = rs_val[1];
      rs1_d     = in_instr[19:15];
      rs2_d     = in_instr[24:20];
      rd_d      = in_instr[11:7];
      imm_d     = dec_imm;
      funct3_d  = in_instr[14:12];
      ctrl_d    = dec_ctrl;
      alu_d     = dec_alu;
      illegal_d = dec_illegal;
    end else if (valid_q && !out_ready && wb_en && wb_rd != 5'd0) begin
      if (wb_rd == rs1_q) rs1_val_d = wb_data;
      if (wb_rd == rs2_q) rs2_val_d = wb_data;
    end
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      funct3_q  <= '0;
      ctrl_q    <= '0;
      alu_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      funct3_q  <= funct3_d;
      ctrl_q    <= ctrl_d;
      alu_q     <= alu_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_rs1_val  = rs1_val_q;
  assign out_rs2_val  = rs2_val_q;
  assign out_rs1      = rs1_q;
  assign out_rs2      = rs2_q;
  assign out_rd       = rd_q;
  assign out_imm      = imm_q;
  assign out_funct3   = funct3_q;
  assign out_ctrl     = ctrl_q;
  assign out_alu_ctrl = alu_q;
  assign out_illegal  = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: RV32I/bypass, RV32E/bypass and RV32I/no-bypass instances against one reference model.
module tb_id_stage_pipe;

  typedef struct packed {
    logic        v;
    logic [31:0] pc, r1v, r2v;
    logic [4:0]  r1, r2, rd;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [10:0] ctrl;
    logic [3:0]  alu;
    logic        ill;
  } ex_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [10:0] ctrl;
    logic [3:0]  alu;
    logic        ill;
  } dec_t;

  logic        clk;
  logic        reset, in_valid, flush, wb_en, out_ready;
  logic [31:0] in_instr, in_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        o_valid [3], o_ready [3], o_ill [3];
  logic [31:0] o_pc [3], o_r1v [3], o_r2v [3], o_imm [3];
  logic [4:0]  o_r1 [3], o_r2 [3], o_rd [3];
  logic [2:0]  o_f3 [3];
  logic [10:0] o_ctrl [3];
  logic [3:0]  o_alu [3];

  int tests = 0;
  int fails = 0;

  ex_t         m [3];
  logic [31:0] rf [3][32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    id_stage_pipe #(.XLEN(32), .NREGS(g == 1 ? 16 : 32), .BYPASS(g == 2 ? 0 : 1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(o_ready[g]),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(o_valid[g]), .out_ready(out_ready), .out_pc(o_pc[g]),
      .out_rs1_val(o_r1v[g]), .out_rs2_val(o_r2v[g]),
      .out_rs1(o_r1[g]), .out_rs2(o_r2[g]), .out_rd(o_rd[g]),
      .out_imm(o_imm[g]), .out_funct3(o_f3[g]), .out_ctrl(o_ctrl[g]),
      .out_alu_ctrl(o_alu[g]), .out_illegal(o_ill[g])
    );
  end

  function automatic int nr(input int k);
    return (k == 1) ? 16 : 32;
  endfunction

  function automatic bit bp(input int k);
    return k != 2;
  endfunction

  task automatic chk(input string tag, input int k, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  function automatic ex_t observed(input int k);
    ex_t o;
    o = '{v: o_valid[k], pc: o_pc[k], r1v: o_r1v[k], r2v: o_r2v[k], r1: o_r1[k], r2: o_r2[k],
          rd: o_rd[k], imm: o_imm[k], f3: o_f3[k], ctrl: o_ctrl[k], alu: o_alu[k], ill: o_ill[k]};
    return o;
  endfunction

  // Reference decode straight from the ISA field rules.
  function automatic dec_t dec(input logic [31:0] ins, input int nregs);
    dec_t d;
    logic signed [31:0] s;
    logic [31:0] t20, t25, t31;
    logic [3:0] f3tab [8];
    int f3, f7;
    bit u1, u2, ud, bad;
    s = ins;
    t20 = s >>> 20;
    t25 = s >>> 25;
    t31 = s >>> 31;
    f3tab = '{4'h0, 4'h5, 4'h8, 4'h9, 4'h4, 4'h6, 4'h3, 4'h2};
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    d = '0; u1 = 0; u2 = 0; ud = 0; bad = 0;
    case (ins[6:0])
      7'h13: begin
        d.imm = t20; d.ctrl = 11'b10001000000; u1 = 1; ud = 1;
        d.alu = (f3 == 5 && ins[30]) ? 4'h7 : f3tab[f3];
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5 && f7 != 0 && f7 != 32) bad = 1;
      end
      7'h33: begin
        d.ctrl = 11'b10000000000; u1 = 1; u2 = 1; ud = 1;
        d.alu = f3tab[f3];
        if (ins[30] && f3 == 0) d.alu = 4'h1;
        if (ins[30] && f3 == 5) d.alu = 4'h7;
        if (f7 != 0 && f7 != 32) bad = 1;
      end
      7'h03: begin d.imm = t20; d.ctrl = 11'b11011000000; u1 = 1; ud = 1; end
      7'h67: begin d.imm = t20; d.ctrl = 11'b10001001000; u1 = 1; ud = 1; end
      7'h23: begin
        d.imm = (t25 << 5) | 32'(ins[11:7]);
        d.ctrl = 11'b00101000000; u1 = 1; u2 = 1;
      end
      7'h63: begin
        d.imm = (t31 << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
        d.ctrl = 11'b00000100000; u1 = 1; u2 = 1;
        d.alu = (f3 < 2) ? 4'h1 : (f3 < 6) ? 4'h8 : 4'h9;
      end
      7'h37: begin d.imm = ins & 32'hFFFFF000; d.ctrl = 11'b10001000100; ud = 1; d.alu = 4'hF; end
      7'h17: begin d.imm = ins & 32'hFFFFF000; d.ctrl = 11'b10001000011; ud = 1; end
      7'h6F: begin
        d.imm = (t31 << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
        d.ctrl = 11'b10000010000; ud = 1;
      end
      7'h73, 7'h0F: ;
      default: d.ill = 1;
    endcase
    if (u1 && int'(ins[19:15]) >= nregs) bad = 1;
    if (u2 && int'(ins[24:20]) >= nregs) bad = 1;
    if (ud && int'(ins[11:7]) >= nregs) bad = 1;
    if (bad) d.ill = 1;
    if (d.ill) d.ctrl = '0;
    return d;
  endfunction

  function automatic logic [31:0] rdm(input int k, input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (bp(k) && wb_en && wb_rd == idx) return wb_data;
    if (int'(idx) < nr(k)) return rf[k][idx];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [11];
    logic [6:0] op, f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    int sel;
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h73, 7'h0F};
    sel = int'($urandom_range(0, 12));
    op = (sel < 11) ? ops[sel] : 7'h7F;
    if (sel == 12) op = 7'(int'($urandom_range(0, 127)));
    rd  = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
    rs1 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
    rs2 = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
    f3  = 3'($urandom_range(0, 7));
    if (op == 7'h63 && f3[2:1] == 2'b01) f3 = 3'b110;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom_range(0, 127));
    endcase
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // One clock: check in_ready, predict the edge, then compare the registered outputs.
  task automatic step();
    ex_t nx [3];
    dec_t d;
    logic rdy, acc;
    #2;
    for (int k = 0; k < 3; k++) begin
      rdy = !reset && !flush && (!m[k].v || out_ready);
      chk("in_ready", k, 192'(o_ready[k]), 192'(rdy));
      acc = in_valid && rdy;
      nx[k] = m[k];
      if (reset) begin
        nx[k] = '0;
      end else begin
        if (acc) begin
          d = dec(in_instr, nr(k));
          nx[k].pc = in_pc;     nx[k].r1 = in_instr[19:15]; nx[k].r2 = in_instr[24:20];
          nx[k].rd = in_instr[11:7]; nx[k].f3 = in_instr[14:12];
          nx[k].r1v = rdm(k, in_instr[19:15]);
          nx[k].r2v = rdm(k, in_instr[24:20]);
          nx[k].imm = d.imm; nx[k].ctrl = d.ctrl; nx[k].alu = d.alu; nx[k].ill = d.ill;
        end else if (m[k].v && !out_ready && wb_en && wb_rd != 0) begin
          if (wb_rd == m[k].r1) nx[k].r1v = wb_data;
          if (wb_rd == m[k].r2) nx[k].r2v = wb_data;
        end
        nx[k].v = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : m[k].v;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) rf[k][r] = 32'h0;
      end else if (wb_en && wb_rd != 0 && int'(wb_rd) < nr(k)) begin
        rf[k][wb_rd] = wb_data;
      end
      m[k] = nx[k];
      chk("out_valid", k, 192'(o_valid[k]), 192'(m[k].v));
      if (m[k].v) chk("idex", k, 192'(observed(k)), 192'(m[k]));
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic rdy_out);
    in_valid = v; in_instr = ins; in_pc = in_pc + 32'd4; out_ready = rdy_out;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0FC; flush = 1'b0;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'h0; out_ready = 1'b0;
    for (int k = 0; k < 3; k++) m[k] = '0;
    @(posedge clk); #1;
    step();
    step();
    for (int k = 0; k < 3; k++) chk("reset_state", k, 192'(observed(k)), 192'(0));

    reset = 1'b0;
    drive(1'b1, 32'h00500093, 1'b1);
    step();
    chk("addi_imm", 0, 192'(o_imm[0]), 192'(32'd5));
    chk("addi_alu", 0, 192'(o_alu[0]), 192'(4'b0000));
    chk("addi_ctrl", 0, 192'(o_ctrl[0]), 192'(11'b10001000000));
    chk("addi_ill", 0, 192'(o_ill[0]), 192'(1'b0));

    drive(1'b1, 32'h00318233, 1'b1);
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000DEAD;
    step();
    chk("byp_rs1", 0, 192'(o_r1v[0]), 192'(32'hDEAD));
    chk("byp_rs2", 0, 192'(o_r2v[0]), 192'(32'hDEAD));
    chk("nobyp_rs1", 2, 192'(o_r1v[2]), 192'(32'h0));

    wb_en = 1'b0;
    drive(1'b1, 32'h407302B3, 1'b1);
    step();
    drive(1'b1, 32'h00500093, 1'b0);
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'h00001234;
    step();
    chk("refresh_rs1", 0, 192'(o_r1v[0]), 192'(32'h1234));
    chk("refresh_rs1", 2, 192'(o_r1v[2]), 192'(32'h1234));
    chk("stall_alu", 0, 192'(o_alu[0]), 192'(4'b0001));
    wb_en = 1'b0;
    #2;
    chk("stall_ready", 0, 192'(o_ready[0]), 192'(1'b0));
    step();

    drive(1'b1, 32'h0020E463, 1'b1);
    step();
    chk("bltu_alu", 0, 192'(o_alu[0]), 192'(4'b1001));
    chk("bltu_ctrl", 0, 192'(o_ctrl[0]), 192'(11'b00000100000));
    chk("bltu_imm", 0, 192'(o_imm[0]), 192'(32'd8));

    drive(1'b1, 32'h40000093, 1'b1);
    step();
    chk("addi30_alu", 0, 192'(o_alu[0]), 192'(4'b0000));
    chk("addi30_imm", 0, 192'(o_imm[0]), 192'(32'h400));

    drive(1'b1, 32'h002088B3, 1'b1);
    step();
    chk("rv32e_ill", 1, 192'(o_ill[1]), 192'(1'b1));
    chk("rv32e_ctrl", 1, 192'(o_ctrl[1]), 192'(11'b0));
    chk("rv32i_ill", 0, 192'(o_ill[0]), 192'(1'b0));

    drive(1'b1, 32'h0000007F, 1'b1);
    step();
    chk("badop_ill", 0, 192'(o_ill[0]), 192'(1'b1));
    chk("badop_ctrl", 0, 192'(o_ctrl[0]), 192'(11'b0));

    drive(1'b1, 32'h00500093, 1'b0);
    flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h00000055;
    step();
    chk("flush_valid", 0, 192'(o_valid[0]), 192'(1'b0));
    flush = 1'b0; wb_en = 1'b0;
    drive(1'b1, 32'h00048533, 1'b1);
    step();
    for (int k = 0; k < 3; k++) chk("flush_wb", k, 192'(o_r1v[k]), 192'(32'h55));

    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rnd_instr();
      in_pc     = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_rd     = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 15)) : 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
